gpr_scoreboard: RTL and testbench

//  Parametrised general-purpose register file that generalises the single-write GPR to NUM_RD

---
 rtl/gpr_scoreboard.sv | 104 ++++++++++
 tb/tb_gpr_scoreboard.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_scoreboard.sv
// Multi-port GPR file with two write ports, optional write-to-read bypass and a
// per-register busy scoreboard used by decode to detect in-flight producers.
module gpr_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wa_clr,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_clr,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic                     sb_flush,
  output logic                     busy_any
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam bit HAS_BYP  = (BYPASS != 0);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Effective write enables: writes to a hardwired-zero index are dropped everywhere,
  // including the bypass path, so index 0 always reads 0.
  logic wa_we;
  logic wb_we;
  logic wa_clr_en;
  logic wb_clr_en;

  assign wa_we     = wa_en && !(HAS_ZERO && (wa_addr == '0));
  assign wb_we     = wb_en && !(HAS_ZERO && (wb_addr == '0));
  assign wa_clr_en = wa_en && wa_clr;
  assign wb_clr_en = wb_en && wb_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wa_we) regs_q[wa_addr] <= wa_data;
      if (wb_we) regs_q[wb_addr] <= wb_data;
    end
  end

  // Priority per index: flush, then new producer, then writeback clear, then hold.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (sb_flush) begin
        busy_d[r] = 1'b0;
      end else if (sb_set_en && (sb_set_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((wa_clr_en && (wa_addr == ADDR_W'(r))) ||
                   (wb_clr_en && (wb_addr == ADDR_W'(r)))) begin
        busy_d[r] = 1'b0;
      end
    end
    if (HAS_ZERO) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_any = |busy_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;
    logic              clr_hit;

    assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
    assign stored  = (HAS_ZERO && (addr == '0)) ? '0 : regs_q[addr];
    assign clr_hit = (wa_clr_en && (wa_addr == addr)) || (wb_clr_en && (wb_addr == addr));

    always_comb begin
      rd_data[p*DATA_W +: DATA_W] = stored;
      if (HAS_BYP) begin
        if (wb_we && (wb_addr == addr))      rd_data[p*DATA_W +: DATA_W] = wb_data;
        else if (wa_we && (wa_addr == addr)) rd_data[p*DATA_W +: DATA_W] = wa_data;
      end
    end

    // A bypassed value is already valid, so the consumer sees the register as not busy.
    assign rd_busy[p] = busy_q[addr] && !(HAS_BYP && clr_hit);
  end

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Bench for gpr_scoreboard: one bypass/zero-reg instance and one plain instance share
// stimulus; both are checked against an array-based model every cycle plus directed literals.
module tb_gpr_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_1, rd_data_0;
  logic [NR-1:0]    rd_busy_1, rd_busy_0;
  logic            busy_any_1, busy_any_0;
  logic            wa_en, wa_clr, wb_en, wb_clr, sb_set_en, sb_flush;
  logic [AW-1:0]   wa_addr, wb_addr, sb_set_addr;
  logic [DW-1:0]   wa_data, wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpr_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_1), .rd_busy(rd_busy_1),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_clr(wa_clr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_clr(wb_clr),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush),
    .busy_any(busy_any_1));

  gpr_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_0), .rd_busy(rd_busy_0),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_clr(wa_clr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_clr(wb_clr),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush),
    .busy_any(busy_any_0));

  // Model: instance k=0 is BYPASS=1/ZERO_REG=1, k=1 is BYPASS=0/ZERO_REG=0.
  logic [DW-1:0] mem [2][NREG];
  bit            bsy [2][NREG];

  function automatic bit is_byp(int k); return (k == 0); endfunction
  function automatic bit is_zr(int k);  return (k == 0); endfunction

  function automatic logic [DW-1:0] exp_rd(int k, int a);
    if (is_zr(k) && a == 0) return '0;
    if (is_byp(k)) begin
      if (wb_en && int'(wb_addr) == a) return wb_data;
      if (wa_en && int'(wa_addr) == a) return wa_data;
    end
    return mem[k][a];
  endfunction

  function automatic bit exp_busy(int k, int a);
    bit hit;
    hit = (wa_en && wa_clr && int'(wa_addr) == a) || (wb_en && wb_clr && int'(wb_addr) == a);
    if (is_zr(k) && a == 0) return 1'b0;
    return bsy[k][a] && !(is_byp(k) && hit);
  endfunction

  function automatic bit exp_any(int k);
    bit o = 1'b0;
    for (int r = 0; r < NREG; r++) o |= bsy[k][r];
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < NREG; r++) begin
          mem[k][r] = '0;
          bsy[k][r] = 1'b0;
        end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wa_en && !(is_zr(k) && wa_addr == 0)) mem[k][wa_addr] = wa_data;
        if (wb_en && !(is_zr(k) && wb_addr == 0)) mem[k][wb_addr] = wb_data;
        if (sb_flush) begin
          for (int r = 0; r < NREG; r++) bsy[k][r] = 1'b0;
        end else begin
          if (wa_en && wa_clr) bsy[k][wa_addr] = 1'b0;
          if (wb_en && wb_clr) bsy[k][wb_addr] = 1'b0;
          if (sb_set_en && !(is_zr(k) && sb_set_addr == 0)) bsy[k][sb_set_addr] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    for (int p = 0; p < NR; p++) begin
      int a;
      a = int'(rd_addr[p*AW +: AW]);
      chk($sformatf("byp_rd_data[%0d]", p), 64'(rd_data_1[p*DW +: DW]), 64'(exp_rd(0, a)));
      chk($sformatf("byp_rd_busy[%0d]", p), 64'(rd_busy_1[p]), 64'(exp_busy(0, a)));
      chk($sformatf("raw_rd_data[%0d]", p), 64'(rd_data_0[p*DW +: DW]), 64'(exp_rd(1, a)));
      chk($sformatf("raw_rd_busy[%0d]", p), 64'(rd_busy_0[p]), 64'(exp_busy(1, a)));
    end
    chk("byp_busy_any", 64'(busy_any_1), 64'(exp_any(0)));
    chk("raw_busy_any", 64'(busy_any_0), 64'(exp_any(1)));
  end

  task automatic idle();
    wa_en = 0; wa_clr = 0; wa_addr = '0; wa_data = '0;
    wb_en = 0; wb_clr = 0; wb_addr = '0; wb_data = '0;
    sb_set_en = 0; sb_set_addr = '0; sb_flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state on every index, both ports.
    for (int i = 0; i < NREG; i++) begin
      step();
      set_rd(i, NREG - 1 - i);
      #1;
      chk("reset_rd_data", 64'(rd_data_1), 64'd0);
      chk("reset_rd_busy", 64'(rd_busy_1), 64'd0);
      chk("reset_busy_any", 64'(busy_any_1), 64'd0);
    end

    // Dual write conflict: port B wins.
    step();
    wa_en = 1; wa_addr = 5; wa_data = 32'h1111;
    wb_en = 1; wb_addr = 5; wb_data = 32'h2222;
    step();
    set_rd(5, 0);
    #1;
    chk("dual_write_byp", 64'(rd_data_1[DW-1:0]), 64'h2222);
    chk("dual_write_raw", 64'(rd_data_0[DW-1:0]), 64'h2222);
    chk("dual_write_model", 64'(mem[0][5]), 64'h2222);

    // Bypass vs stored value.
    step();
    wa_en = 1; wa_addr = 7; wa_data = 32'hDEADBEEF;
    set_rd(7, 5);
    #1;
    chk("bypass_same_cycle", 64'(rd_data_1[DW-1:0]), 64'hDEADBEEF);
    chk("nobypass_old", 64'(rd_data_0[DW-1:0]), 64'h0);
    step();
    set_rd(7, 5);
    #1;
    chk("nobypass_next", 64'(rd_data_0[DW-1:0]), 64'hDEADBEEF);

    // Scoreboard set / bypassed clear / set+clear / flush.
    step();
    sb_set_en = 1; sb_set_addr = 9;
    step();
    set_rd(9, 9);
    #1;
    chk("sb_set_busy", 64'(rd_busy_1[0]), 64'd1);
    chk("sb_set_any", 64'(busy_any_1), 64'd1);
    wb_en = 1; wb_addr = 9; wb_data = 32'h55; wb_clr = 1;
    #1;
    chk("clr_bypass_busy", 64'(rd_busy_1[0]), 64'd0);
    chk("clr_nobypass_busy", 64'(rd_busy_0[0]), 64'd1);
    chk("clr_any_registered", 64'(busy_any_1), 64'd1);
    step();
    #1;
    chk("after_clr_any", 64'(busy_any_1), 64'd0);
    sb_set_en = 1; sb_set_addr = 9;
    wa_en = 1; wa_addr = 9; wa_data = 32'h66; wa_clr = 1;
    step();
    #1;
    chk("set_beats_clr", 64'(rd_busy_1[0]), 64'd1);
    sb_set_en = 1; sb_set_addr = 12;
    step();
    sb_flush = 1;
    wa_en = 1; wa_addr = 12; wa_clr = 0; wa_data = 32'h77;
    step();
    #1;
    chk("flush_any_byp", 64'(busy_any_1), 64'd0);
    chk("flush_any_raw", 64'(busy_any_0), 64'd0);

    // Zero register.
    step();
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF;
    sb_set_en = 1; sb_set_addr = 0;
    #1;
    set_rd(0, 0);
    #1;
    chk("zero_bypass_blocked", 64'(rd_data_1), 64'd0);
    step();
    set_rd(0, 0);
    #1;
    chk("zero_rd_data", 64'(rd_data_1), 64'd0);
    chk("zero_rd_busy", 64'(rd_busy_1), 64'd0);
    chk("nozero_rd_data", 64'(rd_data_0[DW-1:0]), 64'hFFFF);
    chk("nozero_rd_busy", 64'(rd_busy_0[0]), 64'd1);

    // Asynchronous reset in the middle of a write.
    step();
    wb_en = 1; wb_addr = 3; wb_data = 32'hABCD;
    set_rd(5, 7);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_data_byp", 64'(rd_data_1), 64'd0);
    chk("mid_rst_data_raw", 64'(rd_data_0), 64'd0);
    chk("mid_rst_busy_raw", 64'(busy_any_0), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    step();
    set_rd(3, 0);
    #1;
    chk("mid_rst_no_commit", 64'(rd_data_1[DW-1:0]), 64'd0);
    chk("mid_rst_no_commit_raw", 64'(rd_data_0[DW-1:0]), 64'd0);

    // Randomised traffic, with a narrow address window to force collisions.
    for (int n = 0; n < 2000; n++) begin
      int span;
      step();
      if (rst) rst = 1'b0;
      span = ($urandom_range(0, 3) == 0) ? NREG - 1 : 7;
      wa_en       = ($urandom_range(0, 1) == 1);
      wa_addr     = AW'($urandom_range(0, span));
      wa_data     = $urandom;
      wa_clr      = ($urandom_range(0, 1) == 1);
      wb_en       = ($urandom_range(0, 1) == 1);
      wb_addr     = AW'($urandom_range(0, span));
      wb_data     = $urandom;
      wb_clr      = ($urandom_range(0, 1) == 1);
      sb_set_en   = ($urandom_range(0, 2) == 0);
      sb_set_addr = AW'($urandom_range(0, span));
      sb_flush    = ($urandom_range(0, 39) == 0);
      set_rd($urandom_range(0, span), $urandom_range(0, span));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
      end
    end

    step();
    rst = 1'b0;
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
